// File: rtl/voter_if.sv
// voter_if: 4-input vote classifier (WIN/TIE/LOSE) behind an input-stability filter.
// Define VOTER_IF_STATS_EN to add saturating per-verdict counters.
module voter_if #(
    parameter int STABLE_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       I,
    output logic [3:1]       O
`ifdef VOTER_IF_STATS_EN
    ,
    output logic [CNT_W-1:0] win_cnt,
    output logic [CNT_W-1:0] tie_cnt,
    output logic [CNT_W-1:0] lose_cnt
`endif
);
    localparam logic [3:0] THRESH = 4'(STABLE_CYCLES);

    logic [3:0] i_s_q, stab_q, stab_d;
    logic [3:1] o_q, o_d, verdict;
    logic [2:0] votes;
    logic       load;

    // Run length of identical samples saturates at 15; reset value 0 makes the first edge count as 1.
    always_comb begin
        votes   = 3'(I[0]) + 3'(I[1]) + 3'(I[2]) + 3'(I[3]);
        verdict = votes >= 3'd3 ? 3'b100 : votes == 3'd2 ? 3'b010 : 3'b001;
        stab_d  = I != i_s_q ? 4'd1 : stab_q == 4'd15 ? 4'd15 : stab_q + 4'd1;
        load    = stab_d >= THRESH;
        o_d     = load ? verdict : o_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_s_q  <= 4'b0000;
            stab_q <= 4'd0;
            o_q    <= 3'b000;
        end else begin
            i_s_q  <= I;
            stab_q <= stab_d;
            o_q    <= o_d;
        end
    end

    assign O = o_q;

`ifdef VOTER_IF_STATS_EN
    // Index 2 = WIN, 1 = TIE, 0 = LOSE, matching verdict bits [3:1].
    logic [2:0][CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        for (int k = 0; k < 3; k++)
            cnt_d[k] = load && verdict[k+1] && cnt_q[k] != {CNT_W{1'b1}} ? cnt_q[k] + 1'b1 : cnt_q[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign win_cnt  = cnt_q[2];
    assign tie_cnt  = cnt_q[1];
    assign lose_cnt = cnt_q[0];
`endif
endmodule

// File: tb/tb_voter_if.sv
// tb_voter_if: scoreboard bench for voter_if, comparing a history-based reference model
// against two instances (filter depth 1 and 3) under directed and random stimulus.
module tb_voter_if;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct {
        logic [2:0] o1, o3;
        int         c1[3];
        int         c3[3];
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] I;
    logic [3:1] o1, o3;
`ifdef VOTER_IF_STATS_EN
    logic [CW-1:0] w1, t1, l1, w3, t3, l3;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    logic [3:0] hist[$];
    logic [2:0] v1, v3;
    int         c1[3], c3[3];

    always #5 clk = ~clk;

    voter_if #(.STABLE_CYCLES(1), .CNT_W(CW)) u1 (
        .clk(clk), .rst_n(rst_n), .I(I), .O(o1)
`ifdef VOTER_IF_STATS_EN
        , .win_cnt(w1), .tie_cnt(t1), .lose_cnt(l1)
`endif
    );

    voter_if #(.STABLE_CYCLES(3), .CNT_W(CW)) u3 (
        .clk(clk), .rst_n(rst_n), .I(I), .O(o3)
`ifdef VOTER_IF_STATS_EN
        , .win_cnt(w3), .tie_cnt(t3), .lose_cnt(l3)
`endif
    );

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    // Verdict from the vote count alone; bit 2 = WIN, 1 = TIE, 0 = LOSE.
    function automatic logic [2:0] classify(input logic [3:0] x);
        int n = 0;
        for (int b = 0; b < 4; b++) n += int'(x[b]);
        return n >= 3 ? 3'b100 : n == 2 ? 3'b010 : 3'b001;
    endfunction

    function automatic int vidx(input logic [2:0] v);
        return v[2] ? 2 : v[1] ? 1 : 0;
    endfunction

    // Drive one cycle of stimulus between edges and predict the state after the next rising edge.
    task automatic step(input logic [3:0] i, input logic r);
        exp_t e;
        int   run;
        @(negedge clk);
        I     = i;
        rst_n = r;
        if (!r) begin
            hist.delete();
            v1 = 3'b000;
            v3 = 3'b000;
            for (int k = 0; k < 3; k++) begin c1[k] = 0; c3[k] = 0; end
        end else begin
            hist.push_back(i);
            run = 0;
            for (int k = hist.size() - 1; k >= 0 && hist[k] == i && run < 15; k--) run++;
            if (run >= 1) begin
                v1 = classify(i);
                if (c1[vidx(v1)] < CMAX) c1[vidx(v1)]++;
            end
            if (run >= 3) begin
                v3 = classify(i);
                if (c3[vidx(v3)] < CMAX) c3[vidx(v3)]++;
            end
        end
        e.o1 = v1;
        e.o3 = v3;
        e.c1 = c1;
        e.c3 = c3;
        sb.push_back(e);
        if (!r) begin
            #1;
            chk("async_rst_o1", int'(o1), 0);
            chk("async_rst_o3", int'(o3), 0);
        end
    endtask

    // Monitor: one expected entry per rising edge, sampled just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("o_sc1", int'(o1), int'(e.o1));
                chk("o_sc3", int'(o3), int'(e.o3));
                if (e.o1 != 3'b000) chk("onehot_sc1", $countones(o1), 1);
                if (e.o3 != 3'b000) chk("onehot_sc3", $countones(o3), 1);
`ifdef VOTER_IF_STATS_EN
                chk("win_sc1", int'(w1), e.c1[2]);
                chk("tie_sc1", int'(t1), e.c1[1]);
                chk("lose_sc1", int'(l1), e.c1[0]);
                chk("win_sc3", int'(w3), e.c3[2]);
                chk("tie_sc3", int'(t3), e.c3[1]);
                chk("lose_sc3", int'(l3), e.c3[0]);
`endif
            end
        end
    end

    initial begin
        logic [3:0] cur;
        rst_n = 1'b0;
        I     = 4'b1111;
        v1    = 3'b000;
        v3    = 3'b000;
        for (int k = 0; k < 3; k++) begin c1[k] = 0; c3[k] = 0; end
        #1;
        chk("reset_o1", int'(o1), 0);
        chk("reset_o3", int'(o3), 0);
        repeat (3) step(4'b1111, 1'b0);
        repeat (3) step(4'b1111, 1'b1);
        step(4'b1111, 1'b0);
        repeat (5) step(4'b1111, 1'b1);
        for (int v = 0; v < 16; v++) step(4'(v), 1'b1);
        repeat (3) step(4'b0000, 1'b1);
        repeat (2) step(4'b0011, 1'b1);
        step(4'b0000, 1'b1);
        repeat (3) step(4'b0011, 1'b1);
        repeat (4) step(4'b1111, 1'b1);
        step(4'b1111, 1'b0);
        repeat (2) step(4'b0101, 1'b1);
        cur = 4'b0000;
        repeat (1000) begin
            if ($urandom_range(0, 3) == 0) cur = 4'($urandom);
            step(cur, 1'b1);
        end
        @(posedge clk);
        #2;
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
